// File: rtl/wb_arbiter.sv
// Purpose: round-robin writeback arbiter feeding the scalar regfile write port,
//          plus a 32-entry pending-write scoreboard used by issue for RAW stalls.
// Latency: 1 cycle from the accepting edge to rd_addr_o/rd_data_o/reg_write_en_o.
// Backpressure: the sink always accepts, so one source is granted every cycle
//          in which any source is valid; ungranted sources hold their result.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   src_valid_i/src_ready_o   per-source valid/ready (index 0=ALU, 1=LSU, 2=MDU)
//   src_rd_i, src_data_i      per-source destination register and result, packed
//   rd_addr_o, rd_data_o,
//   reg_write_en_o            registered regfile write port
//   sb_set_i, sb_set_rd_i     issue-side allocation of a pending write
//   busy_o                    scoreboard, bit r set while a write to xr is pending
module wb_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SRC    = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC-1:0]            src_valid_i,
  output logic [NUM_SRC-1:0]            src_ready_o,
  input  logic [NUM_SRC*5-1:0]          src_rd_i,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data_i,
  output logic [4:0]                    rd_addr_o,
  output logic [DATA_WIDTH-1:0]         rd_data_o,
  output logic                          reg_write_en_o,
  input  logic                          sb_set_i,
  input  logic [4:0]                    sb_set_rd_i,
  output logic [31:0]                   busy_o
);

  localparam int PTR_W = $clog2(NUM_SRC);

  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [4:0]            rd_addr_q, rd_addr_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  wen_q, wen_d;
  logic [31:0]           busy_q, busy_d;

  logic [2*NUM_SRC-1:0]  vld_rot;
  logic [NUM_SRC-1:0]    grant;
  logic [PTR_W-1:0]      win;
  logic                  any_vld;
  logic                  xfer;
  logic [4:0]            sel_rd;
  logic [DATA_WIDTH-1:0] sel_dat;

  // Rotate the valid vector so bit k corresponds to source (ptr+k) mod NUM_SRC;
  // the first set bit in the low NUM_SRC positions is the winner.
  always_comb begin
    int w;
    vld_rot = {src_valid_i, src_valid_i} >> ptr_q;
    any_vld = 1'b0;
    win     = '0;
    w       = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!any_vld && vld_rot[k]) begin
        any_vld = 1'b1;
        w       = int'(ptr_q) + k;
        if (w >= NUM_SRC) w = w - NUM_SRC;
        win     = PTR_W'(w);
      end
    end
    grant = '0;
    if (any_vld) grant[win] = 1'b1;
  end

  // Ready is combinational on valid; nothing is accepted while reset is held.
  assign src_ready_o = rst ? '0 : grant;
  assign xfer        = any_vld && !rst;

  always_comb begin
    sel_rd  = '0;
    sel_dat = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant[i]) begin
        sel_rd  = src_rd_i[i*5 +: 5];
        sel_dat = src_data_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    ptr_d     = ptr_q;
    rd_addr_d = rd_addr_q;
    rd_data_d = rd_data_q;
    wen_d     = 1'b0;
    if (xfer) begin
      ptr_d     = (win == PTR_W'(NUM_SRC - 1)) ? '0 : win + 1'b1;
      rd_addr_d = sel_rd;
      rd_data_d = sel_dat;
      // x0 results are consumed but never written.
      wen_d     = (sel_rd != 5'd0);
    end

    // Clear on the regfile commit edge first, so a same-edge set on the same
    // register (a newer outstanding write) wins.
    busy_d = busy_q;
    if (wen_q) busy_d[rd_addr_q] = 1'b0;
    if (sb_set_i && (sb_set_rd_i != 5'd0)) busy_d[sb_set_rd_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= '0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
      wen_q     <= 1'b0;
      busy_q    <= '0;
    end else begin
      ptr_q     <= ptr_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
      wen_q     <= wen_d;
      busy_q    <= busy_d;
    end
  end

  assign rd_addr_o      = rd_addr_q;
  assign rd_data_o      = rd_data_q;
  assign reg_write_en_o = wen_q;
  assign busy_o         = busy_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter (NUM_SRC=3, DATA_WIDTH=32).
// Inputs change 1ns after a rising edge; ready is checked once settled in the
// same cycle, registered outputs are checked 1ns after the following edge.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  src_valid = 3'b000;
  logic [2:0]  src_ready;
  logic [4:0]  rd [3];
  logic [31:0] dat [3];
  logic [14:0] src_rd;
  logic [95:0] src_data;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        wen;
  logic        sb_set = 1'b0;
  logic [4:0]  sb_set_rd = 5'd0;
  logic [31:0] busy;

  int total = 0;
  int bad   = 0;

  assign src_rd   = {rd[2], rd[1], rd[0]};
  assign src_data = {dat[2], dat[1], dat[0]};

  always #5 clk = ~clk;

  wb_arbiter #(.DATA_WIDTH(32), .NUM_SRC(3)) dut (
    .clk            (clk),
    .rst            (rst),
    .src_valid_i    (src_valid),
    .src_ready_o    (src_ready),
    .src_rd_i       (src_rd),
    .src_data_i     (src_data),
    .rd_addr_o      (rd_addr),
    .rd_data_o      (rd_data),
    .reg_write_en_o (wen),
    .sb_set_i       (sb_set),
    .sb_set_rd_i    (sb_set_rd),
    .busy_o         (busy)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rd[0] = 5'd1; rd[1] = 5'd2; rd[2] = 5'd3;
    dat[0] = 32'h0; dat[1] = 32'h0; dat[2] = 32'h0;
    rst = 1'b1;
    src_valid = 3'b111;
    next_cycle();
    next_cycle();
    total++; if (src_ready !== 3'b000) begin bad++; $display("FAIL reset_ready got=%b exp=000", src_ready); end
    total++; if (wen !== 1'b0) begin bad++; $display("FAIL reset_wen got=%b exp=0", wen); end
    total++; if (busy !== 32'h0) begin bad++; $display("FAIL reset_busy got=%h exp=0", busy); end
    total++; if (rd_addr !== 5'd0 || rd_data !== 32'h0) begin bad++; $display("FAIL reset_out got=%0d/%h exp=0/0", rd_addr, rd_data); end
    rst = 1'b0;
    #1;
    total++; if (src_ready !== 3'b001) begin bad++; $display("FAIL reset_first_grant got=%b exp=001", src_ready); end
    src_valid = 3'b000;
    next_cycle();
  endtask

  task automatic test_single_alu();
    rd[0] = 5'd5; dat[0] = 32'hDEADBEEF;
    src_valid = 3'b001;
    #1;
    total++; if (src_ready !== 3'b001) begin bad++; $display("FAIL single_ready got=%b exp=001", src_ready); end
    next_cycle();
    src_valid = 3'b000;
    total++; if (wen !== 1'b1 || rd_addr !== 5'd5 || rd_data !== 32'hDEADBEEF) begin
      bad++; $display("FAIL single_write got=%b/%0d/%h exp=1/5/deadbeef", wen, rd_addr, rd_data);
    end
    next_cycle();
    total++; if (wen !== 1'b0 || rd_addr !== 5'd5) begin bad++; $display("FAIL single_idle got=%b/%0d exp=0/5", wen, rd_addr); end
  endtask

  // Pointer is 1 after the single ALU write, so the rotation starts at source 1.
  task automatic test_round_robin();
    logic [2:0]  vld_seq [8] = '{3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b110, 3'b100};
    logic [2:0]  rdy_seq [8] = '{3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    logic [4:0]  adr_seq [8] = '{5'd2, 5'd3, 5'd1, 5'd2, 5'd3, 5'd1, 5'd2, 5'd3};
    logic [31:0] dat_seq [8] = '{32'hB2, 32'hC3, 32'hA1, 32'hB2, 32'hC3, 32'hA1, 32'hB2, 32'hC3};
    rd[0] = 5'd1; rd[1] = 5'd2; rd[2] = 5'd3;
    dat[0] = 32'hA1; dat[1] = 32'hB2; dat[2] = 32'hC3;
    for (int i = 0; i < 8; i++) begin
      src_valid = vld_seq[i];
      #1;
      total++; if (src_ready !== rdy_seq[i]) begin bad++; $display("FAIL rr_ready[%0d] got=%b exp=%b", i, src_ready, rdy_seq[i]); end
      next_cycle();
      total++; if (wen !== 1'b1 || rd_addr !== adr_seq[i] || rd_data !== dat_seq[i]) begin
        bad++; $display("FAIL rr_write[%0d] got=%b/%0d/%h exp=1/%0d/%h", i, wen, rd_addr, rd_data, adr_seq[i], dat_seq[i]);
      end
    end
    src_valid = 3'b000;
    next_cycle();
  endtask

  task automatic test_x0_discard();
    rd[1] = 5'd0; dat[1] = 32'h1234;
    src_valid = 3'b010;
    #1;
    total++; if (src_ready !== 3'b010) begin bad++; $display("FAIL x0_ready got=%b exp=010", src_ready); end
    next_cycle();
    src_valid = 3'b000;
    total++; if (wen !== 1'b0) begin bad++; $display("FAIL x0_wen got=%b exp=0", wen); end
    total++; if (busy !== 32'h0) begin bad++; $display("FAIL x0_busy got=%h exp=0", busy); end
    next_cycle();
  endtask

  // Pointer is 2 here; each MDU grant returns it to 0.
  task automatic test_scoreboard();
    sb_set = 1'b1; sb_set_rd = 5'd7;
    next_cycle();
    sb_set = 1'b0;
    total++; if (busy !== 32'h0000_0080) begin bad++; $display("FAIL sb_set got=%h exp=00000080", busy); end

    rd[2] = 5'd7; dat[2] = 32'hCAFE0007;
    src_valid = 3'b100;
    #1;
    total++; if (src_ready !== 3'b100) begin bad++; $display("FAIL sb_mdu_ready got=%b exp=100", src_ready); end
    next_cycle();
    src_valid = 3'b000;
    total++; if (wen !== 1'b1 || rd_addr !== 5'd7 || busy !== 32'h0000_0080) begin
      bad++; $display("FAIL sb_hold got=%b/%0d/%h exp=1/7/00000080", wen, rd_addr, busy);
    end
    next_cycle();
    total++; if (busy !== 32'h0) begin bad++; $display("FAIL sb_clear got=%h exp=0", busy); end

    // Set and clear of x7 on the same edge: the set wins.
    sb_set = 1'b1; sb_set_rd = 5'd7;
    next_cycle();
    sb_set = 1'b0;
    src_valid = 3'b100;
    next_cycle();
    src_valid = 3'b000;
    sb_set = 1'b1; sb_set_rd = 5'd7;
    total++; if (wen !== 1'b1 || busy !== 32'h0000_0080) begin bad++; $display("FAIL sb_pre_collide got=%b/%h exp=1/00000080", wen, busy); end
    next_cycle();
    sb_set = 1'b0;
    total++; if (busy !== 32'h0000_0080) begin bad++; $display("FAIL sb_set_wins got=%h exp=00000080", busy); end
    next_cycle();
    total++; if (busy !== 32'h0000_0080) begin bad++; $display("FAIL sb_still_busy got=%h exp=00000080", busy); end

    // Clear x7 while setting x3 on the same edge: both apply.
    src_valid = 3'b100;
    next_cycle();
    src_valid = 3'b000;
    sb_set = 1'b1; sb_set_rd = 5'd3;
    next_cycle();
    total++; if (busy !== 32'h0000_0008) begin bad++; $display("FAIL sb_set_clear_diff got=%h exp=00000008", busy); end

    // A set of x0 is ignored.
    sb_set_rd = 5'd0;
    next_cycle();
    sb_set = 1'b0;
    total++; if (busy !== 32'h0000_0008) begin bad++; $display("FAIL sb_x0 got=%h exp=00000008", busy); end
  endtask

  task automatic test_reset_mid();
    // Grant source 0 so the pointer moves to 1 before the reset.
    rd[0] = 5'd1; dat[0] = 32'h11;
    src_valid = 3'b001;
    next_cycle();
    rd[2] = 5'd9; dat[2] = 32'h99;
    src_valid = 3'b100;
    #1;
    total++; if (src_ready !== 3'b100) begin bad++; $display("FAIL mid_ready got=%b exp=100", src_ready); end
    rst = 1'b1;
    #1;
    total++; if (src_ready !== 3'b000) begin bad++; $display("FAIL mid_ready_rst got=%b exp=000", src_ready); end
    next_cycle();
    total++; if (wen !== 1'b0 || rd_addr !== 5'd0 || busy !== 32'h0) begin
      bad++; $display("FAIL mid_dropped got=%b/%0d/%h exp=0/0/0", wen, rd_addr, busy);
    end
    rst = 1'b0;
    src_valid = 3'b111;
    #1;
    total++; if (src_ready !== 3'b001) begin bad++; $display("FAIL mid_ptr_restart got=%b exp=001", src_ready); end
    next_cycle();
    total++; if (wen !== 1'b1 || rd_addr !== 5'd1 || rd_data !== 32'h11) begin
      bad++; $display("FAIL mid_after got=%b/%0d/%h exp=1/1/11", wen, rd_addr, rd_data);
    end
    src_valid = 3'b110;
    next_cycle();
    src_valid = 3'b100;
    next_cycle();
    src_valid = 3'b000;
    total++; if (wen !== 1'b1 || rd_addr !== 5'd9 || rd_data !== 32'h99) begin
      bad++; $display("FAIL mid_held_mdu got=%b/%0d/%h exp=1/9/99", wen, rd_addr, rd_data);
    end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_single_alu();
    test_round_robin();
    test_x0_discard();
    test_scoreboard();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback stage directly upstream of the scalar register file; its outputs drive the regfile write port (rd_addr_i, rd_data_i, reg_write_en_i).
- Arbitrates round-robin among NUM_SRC result producers (ALU, LSU load, MDU) using valid/ready handshakes.
- Registers the winning write for one cycle.
- Maintains a 32-bit pending-write scoreboard that issue logic uses for RAW hazard stalls.

Parameters:
- DATA_WIDTH, 32, data width of a register write.
- NUM_SRC, 3, number of result sources; index 0 = ALU, 1 = LSU, 2 = MDU; legal range 2..8.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- src_valid_i  input  NUM_SRC  per-source result valid.
- src_ready_o  output  NUM_SRC  per-source grant/accept.
- src_rd_i  input  NUM_SRC*5  per-source destination register; source i occupies bits [5i+4:5i].
- src_data_i  input  NUM_SRC*DATA_WIDTH  per-source result data, packed like src_rd_i.
- rd_addr_o  output  5  to regfile rd_addr_i.
- rd_data_o  output  DATA_WIDTH  to regfile rd_data_i.
- reg_write_en_o  output  1  to regfile reg_write_en_i.
- sb_set_i  input  1  issue allocates a pending write to sb_set_rd_i.
- sb_set_rd_i  input  5  register being allocated.
- busy_o  output  32  scoreboard; bit r=1 means a write to xr is outstanding.

Behaviour:
- Reset (rst=1 at a rising edge):
  - reg_write_en_o=0, rd_addr_o=0, rd_data_o=0.
  - busy_o=0; round-robin pointer=0.
  - In-flight registered write is dropped; a write in flight when reset is sampled never reaches the regfile.
  - src_ready_o is combinational and forced to 0 while rst=1.
- Arbitration (combinational, every cycle):
  - Winner = first i with src_valid_i[i]=1, searching ptr, ptr+1, ... modulo NUM_SRC.
  - src_ready_o is one-hot on the winner, or all-zero if no source is valid.
  - src_ready_o[i] may depend on src_valid_i; sources must not make valid depend on ready.
  - Sink always accepts, so exactly one grant per cycle whenever any valid=1. Throughput 1 write/cycle.
- Handshake:
  - A transfer occurs on an edge where src_valid_i[i] && src_ready_o[i].
  - A non-granted source holds valid, rd and data stable until granted.
  - Valid does not drop without a transfer (outside reset).
- Pointer:
  - After a transfer from source g, ptr <= (g+1) mod NUM_SRC.
  - Unchanged when nothing is granted.
  - Wrap-around: grant of NUM_SRC-1 sets ptr=0.
- Output stage, fixed 1-cycle latency:
  - On a transfer edge: rd_addr_o <= src rd, rd_data_o <= src data, reg_write_en_o <= (src rd != 0).
  - With no transfer: reg_write_en_o <= 0; rd_addr_o and rd_data_o hold their previous values.
  - A result with rd=x0 is accepted (ready=1) but never produces a write enable.
- Scoreboard, updated each edge:
  - Clear: if reg_write_en_o=1, busy[rd_addr_o] <= 0. This is the same edge the regfile commits, so busy=0 is seen only once the regfile holds the new value.
  - Set: if sb_set_i=1 and sb_set_rd_i!=0, busy[sb_set_rd_i] <= 1.
  - Set and clear on the same register in the same edge: set wins (busy stays 1, newer write outstanding).
  - Set and clear on different registers both apply.
  - busy_o[0] is constant 0.
  - Set of an already-busy register leaves it 1; no counting.
- No other state; no internal buffering beyond the single output register.

Test Plan:
- Reset check: assert rst for 2 cycles with all sources valid -> src_ready_o=0, reg_write_en_o=0, busy_o=0. Release rst -> first grant goes to source 0.
- Single ALU result: src_valid_i=3'b001, rd=5, data=0xDEADBEEF -> ready[0]=1 that cycle; next cycle reg_write_en_o=1, rd_addr_o=5, rd_data_o=0xDEADBEEF; the cycle after, reg_write_en_o=0.
- Round-robin and wrap: all three valid continuously with distinct rd 1/2/3 -> grants in order 0,1,2,0,1,2; rd_addr_o sequence 1,2,3,1,2,3 on consecutive cycles; no idle cycles.
- x0 discard: source 1 valid with rd=0, data=0x1234 -> ready[1]=1; next cycle reg_write_en_o=0; busy_o unchanged.
- Scoreboard:
  - sb_set_i with rd=7 -> busy_o[7]=1 next cycle.
  - MDU (source 2) writes rd=7 -> busy_o[7] stays 1 while reg_write_en_o=1 and clears the following cycle.
  - Repeat with sb_set_i rd=7 on the clearing edge -> busy_o[7] remains 1.
- Reset mid-operation: source 2 granted with rd=9, and rst=1 on the next edge -> reg_write_en_o never asserts for rd=9, busy_o=0, and ptr restarts at 0.
